// File: rtl/noise_pkg.sv
// Shared constants and types for the noise arbiter: default polynomial,
// FSM state encoding and step-counter width.
package noise_pkg;

   localparam logic [8:0] NOISE_POLY_8 = 9'h11D;
   localparam int         NOISE_CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      DELIVER = 2'd2
   } noise_state_e;

endpackage

// File: rtl/noise_lfsr_core.sv
// Right-shift Galois LFSR with enable and parallel load; a load of zero is
// forced to 1 so the register can never lock up.
module noise_lfsr_core #(
   parameter int         W    = 8,
   parameter logic [W:0] POLY = 9'h11D
) (
   input  logic         clk,
   input  logic         nCR,
   input  logic         en,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   output logic [W-1:0] state
);

   localparam logic [W-1:0] TAPS = POLY[W:1];
   localparam logic [W-1:0] ONE  = W'(1);

   logic [W-1:0] state_q;
   logic [W-1:0] state_d;

   always_comb begin
      state_d = state_q;
      if (ld) begin
         state_d = (ld_val == '0) ? ONE : ld_val;
      end else if (en) begin
         state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
      end
   end

   always_ff @(posedge clk or negedge nCR) begin
      if (!nCR) begin
         state_q <= ONE;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/noise_arbiter.sv
// Round-robin sharing of one Galois LFSR noise source between N_REQ requesters.
// Optional seed load port: define NOISE_ARB_SEED_LOAD_EN.
module noise_arbiter
   import noise_pkg::*;
#(
   parameter int         N_REQ = 4,
   parameter int         W     = 8,
   parameter logic [W:0] POLY  = NOISE_POLY_8,
   parameter int         STEPS = 8
) (
   input  logic             clk,
   input  logic             nCR,
`ifdef NOISE_ARB_SEED_LOAD_EN
   input  logic             seed_we,
   input  logic [W-1:0]     seed,
`endif
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             vld,
   output logic [W-1:0]     data,
   output logic             busy
);

   localparam int PW = $clog2(N_REQ);
   localparam logic [NOISE_CNT_W-1:0] STEPS_C = NOISE_CNT_W'(STEPS);

   noise_state_e            state_q, state_d;
   logic [NOISE_CNT_W-1:0]  cnt_q, cnt_d;
   logic [N_REQ-1:0]        gnt_q, gnt_d;
   logic [PW-1:0]           ptr_q, ptr_d;
   logic                    vld_q, vld_d;
   logic [W-1:0]            data_q, data_d;

   logic                    pick_any;
   logic [PW-1:0]           pick_idx;
   logic [N_REQ-1:0]        pick_oh;
   int                      cand;

   logic                    lfsr_en;
   logic                    lfsr_ld;
   logic [W-1:0]            lfsr_ld_val;
   logic [W-1:0]            lfsr_state;

   // Value the LFSR takes on its final SHIFT edge, captured into data so it
   // appears in the same cycle as vld.
   function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
      return s[0] ? ((s >> 1) ^ POLY[W:1]) : (s >> 1);
   endfunction

   noise_lfsr_core #(
      .W    (W),
      .POLY (POLY)
   ) u_lfsr (
      .clk    (clk),
      .nCR    (nCR),
      .en     (lfsr_en),
      .ld     (lfsr_ld),
      .ld_val (lfsr_ld_val),
      .state  (lfsr_state)
   );

   // Scan from farthest to nearest so the closest requester after ptr wins.
   always_comb begin
      pick_any = 1'b0;
      pick_idx = ptr_q;
      pick_oh  = '0;
      cand     = 0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = int'(ptr_q) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         if (req[PW'(cand)]) begin
            pick_any = 1'b1;
            pick_idx = PW'(cand);
         end
      end
      if (pick_any) begin
         pick_oh[pick_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      vld_d   = 1'b0;
      data_d  = data_q;
      case (state_q)
         IDLE, DELIVER: begin
            if (pick_any) begin
               gnt_d   = pick_oh;
               ptr_d   = pick_idx;
               cnt_d   = STEPS_C;
               state_d = SHIFT;
            end else begin
               gnt_d   = '0;
               state_d = IDLE;
            end
         end
         SHIFT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == NOISE_CNT_W'(1)) begin
               state_d = DELIVER;
               vld_d   = 1'b1;
               data_d  = lfsr_next(lfsr_state);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      busy    = (state_q != IDLE);
      lfsr_en = (state_q == SHIFT);
`ifdef NOISE_ARB_SEED_LOAD_EN
      lfsr_ld     = seed_we && (state_q == IDLE);
      lfsr_ld_val = seed;
`else
      lfsr_ld     = 1'b0;
      lfsr_ld_val = '0;
`endif
   end

   always_ff @(posedge clk or negedge nCR) begin
      if (!nCR) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge nCR) begin
      if (!nCR) begin
         cnt_q  <= '0;
         gnt_q  <= '0;
         ptr_q  <= PW'(N_REQ - 1);
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         gnt_q  <= gnt_d;
         ptr_q  <= ptr_d;
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign gnt  = gnt_q;
   assign vld  = vld_q;
   assign data = data_q;

endmodule

// File: tb/tb_noise_arbiter.sv
// Self-checking bench for noise_arbiter (N_REQ=4, W=8, STEPS=8) with a
// delivery scoreboard fed by a round-robin / LFSR reference model.
module tb_noise_arbiter;

   logic       clk;
   logic       nCR;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       vld;
   logic [7:0] data;
   logic       busy;
`ifdef NOISE_ARB_SEED_LOAD_EN
   logic       seed_we;
   logic [7:0] seed;
`endif

   typedef struct packed {
      logic [3:0] g;
      logic [7:0] d;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_lfsr = 8'h01;
   int         model_ptr  = 3;
   logic [7:0] last_data  = 8'h00;

   noise_arbiter #(
      .N_REQ (4),
      .W     (8),
      .POLY  (9'h11D),
      .STEPS (8)
   ) dut (
      .clk     (clk),
      .nCR     (nCR),
`ifdef NOISE_ARB_SEED_LOAD_EN
      .seed_we (seed_we),
      .seed    (seed),
`endif
      .req     (req),
      .gnt     (gnt),
      .vld     (vld),
      .data    (data),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return s[0] ? ((s >> 1) ^ 8'h8E) : (s >> 1);
   endfunction

   function automatic int rr_next(input int last, input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic expect_delivery(input logic [3:0] r);
      exp_t e;
      int   idx;
      idx       = rr_next(model_ptr, r);
      model_ptr = idx;
      for (int i = 0; i < 8; i++) model_lfsr = lfsr_step(model_lfsr);
      e.g       = 4'(1 << idx);
      e.d       = model_lfsr;
      last_data = model_lfsr;
      exp_q.push_back(e);
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      req = 4'b0000;
      nCR = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nCR        = 1'b1;
      model_lfsr = 8'h01;
      model_ptr  = 3;
   endtask

   // Scoreboard: every vld pops one expected delivery.
   always @(negedge clk) begin
      if (nCR && vld) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_vld: gnt=%b data=%02h, no delivery expected", gnt, data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("deliver gnt=%b data=%02h (expected gnt=%b data=%02h)", gnt, data, e.g, e.d);
            if (gnt !== e.g || data !== e.d) begin
               errors++;
               $display("FAIL delivery: got gnt=%b data=%02h, expected gnt=%b data=%02h", gnt, data, e.g, e.d);
            end
         end
      end
   end

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_vld: %0d deliveries outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset;
      nCR = 1'b0;
      req = 4'b0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({gnt, vld, data, busy} !== 14'h0) begin
         errors++;
         $display("FAIL reset_outputs: gnt=%b vld=%b data=%02h busy=%b, expected all 0", gnt, vld, data, busy);
      end
      @(posedge clk);
      #1;
      nCR        = 1'b1;
      model_lfsr = 8'h01;
      model_ptr  = 3;
   endtask

   task automatic test_single;
      next_cycle();
      req = 4'b0001;
      expect_delivery(4'b0001);
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         checks++;
         if (gnt !== ((c >= 1 && c <= 9) ? 4'b0001 : 4'b0000) || vld !== (c == 9) || busy !== (c >= 1 && c <= 9)) begin
            errors++;
            $display("FAIL single_c%0d: gnt=%b vld=%b busy=%b", c, gnt, vld, busy);
         end
         if (c == 9) begin
            checks++;
            if (data !== 8'h83) begin
               errors++;
               $display("FAIL single_data: got %02h, expected 83", data);
            end
            req = 4'b0000;
         end
      end
      check_drained("single");
   endtask

   task automatic test_round_robin;
      logic [3:0] order_oh [5];
      logic [3:0] g_exp;
      order_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      next_cycle();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) expect_delivery(4'b1111);
      for (int c = 0; c <= 46; c++) begin
         @(negedge clk);
         g_exp = (c >= 1 && c <= 45) ? order_oh[(c - 1) / 9] : 4'b0000;
         checks++;
         if (gnt !== g_exp || busy !== (c >= 1 && c <= 45) || vld !== (c > 0 && c <= 45 && c % 9 == 0)) begin
            errors++;
            $display("FAIL rr_c%0d: gnt=%b busy=%b vld=%b, expected gnt=%b", c, gnt, busy, vld, g_exp);
         end
         if (c == 45) req = 4'b0000;
      end
      check_drained("rr");
   endtask

   task automatic test_pulse;
      next_cycle();
      req = 4'b0001;
      expect_delivery(4'b0001);
      next_cycle();
      req = 4'b0000;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         checks++;
         if (gnt !== ((c <= 9) ? 4'b0001 : 4'b0000) || vld !== (c == 9) || busy !== (c <= 9)) begin
            errors++;
            $display("FAIL pulse_c%0d: gnt=%b vld=%b busy=%b", c, gnt, vld, busy);
         end
      end
      check_drained("pulse");
   endtask

   task automatic test_reset_mid;
      next_cycle();
      req = 4'b0001;
      for (int c = 0; c <= 4; c++) @(negedge clk);
      nCR = 1'b0;
      req = 4'b0000;
      #1;
      checks++;
      if ({gnt, vld, data, busy} !== 14'h0) begin
         errors++;
         $display("FAIL midreset_outputs: gnt=%b vld=%b data=%02h busy=%b, expected all 0", gnt, vld, data, busy);
      end
      repeat (2) @(posedge clk);
      #1;
      nCR        = 1'b1;
      model_lfsr = 8'h01;
      model_ptr  = 3;
      next_cycle();
      req = 4'b0001;
      expect_delivery(4'b0001);
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         if (c == 9) begin
            checks++;
            if (vld !== 1'b1 || data !== 8'h83) begin
               errors++;
               $display("FAIL midreset_redeliver: vld=%b data=%02h, expected vld=1 data=83", vld, data);
            end
            req = 4'b0000;
         end
      end
      check_drained("midreset");
   endtask

   task automatic test_back_to_back;
      logic [3:0] g_exp;
      do_reset();
      next_cycle();
      req = 4'b0100;
      expect_delivery(4'b0100);
      expect_delivery(4'b1010);
      expect_delivery(4'b0010);
      for (int c = 0; c <= 29; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= 9)        g_exp = 4'b0100;
         else if (c >= 10 && c <= 18) g_exp = 4'b1000;
         else if (c >= 19 && c <= 27) g_exp = 4'b0010;
         else                         g_exp = 4'b0000;
         checks++;
         if (gnt !== g_exp) begin
            errors++;
            $display("FAIL b2b_gnt_c%0d: got %b, expected %b", c, gnt, g_exp);
         end
         if (c == 9)  req = 4'b1010;
         if (c == 18) req = 4'b0010;
         if (c == 27) req = 4'b0000;
         if (c == 29) begin
            checks++;
            if (data !== last_data || busy !== 1'b0) begin
               errors++;
               $display("FAIL b2b_hold: data=%02h busy=%b, expected data=%02h busy=0", data, busy, last_data);
            end
         end
      end
      check_drained("b2b");
   endtask

`ifdef NOISE_ARB_SEED_LOAD_EN
   task automatic test_seed_load;
      next_cycle();
      seed_we = 1'b1;
      seed    = 8'h00;
      next_cycle();
      seed_we    = 1'b0;
      model_lfsr = 8'h01;
      req        = 4'b0010;
      expect_delivery(4'b0010);
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         if (c == 3) begin
            seed_we = 1'b1;
            seed    = 8'h55;
         end
         if (c == 4) seed_we = 1'b0;
         if (c == 9) begin
            checks++;
            if (data !== 8'h83) begin
               errors++;
               $display("FAIL seed_zero_guard: got %02h, expected 83", data);
            end
            req = 4'b0000;
         end
      end
      check_drained("seed");
   endtask
`endif

   initial begin
      req = 4'b0000;
      nCR = 1'b0;
`ifdef NOISE_ARB_SEED_LOAD_EN
      seed_we = 1'b0;
      seed    = 8'h00;
`endif
      test_reset();
      test_single();
      test_round_robin();
      test_pulse();
      test_reset_mid();
      test_back_to_back();
`ifdef NOISE_ARB_SEED_LOAD_EN
      test_seed_load();
`endif
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/noise_arbiter.md
# noise_arbiter

Round-robin scheduler that shares one 8-bit Galois LFSR noise source (polynomial 0x11D, right-shift form) between up to N_REQ requesters. For each granted request the block advances the LFSR a programmable number of steps so that consecutive deliveries are decorrelated. It then presents one noise word with a single-cycle valid strobe. It sits between the noise LFSR core and the consumers, such as display or audio dither blocks, that previously each instantiated a private generator.

## Interface
- N_REQ, 4: number of requesters, 2..8
- W, 8: LFSR/data width
- POLY, 9'h11D: feedback polynomial, including the x^W term
- STEPS, 8: LFSR advances per delivery, 1..255
- clk  in  1  single clock, rising edge
- nCR  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-requester request level, held until its delivery
- gnt  out  N_REQ  one-hot grant, registered
- vld  out  1  one-cycle strobe: data valid for the granted requester
- data  out  W  delivered noise word, registered, held between deliveries
- busy  out  1  high whenever state is not IDLE
- seed_we  in  1  seed load strobe (only with NOISE_ARB_SEED_LOAD_EN)
- seed  in  W  seed value (only with NOISE_ARB_SEED_LOAD_EN)

## Operation
- State machine:
  - IDLE: when any req bit is high, arbitrate, register gnt, load step counter with STEPS, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: LFSR advances once per cycle with enable high and the counter decrements. Leave for DELIVER after the STEPS-th advance.
  - DELIVER: data <= LFSR state, vld=1, gnt still held. Re-arbitrate on current req. If any request is present, go to SHIFT with the new gnt; otherwise clear gnt and go to IDLE.
- LFSR step: if state[0], state <= (state>>1) ^ (POLY>>1); else state <= state>>1. The LFSR never advances outside SHIFT.
- Round robin:
  - Search starts at the index after the last granted requester, wrapping at N_REQ-1 to 0.
  - After reset the last-granted pointer is N_REQ-1, so requester 0 has highest priority first.
  - The pointer updates only when a grant is issued.
- Requester behaviour:
  - A requester dropping req during SHIFT does not abort the operation. The delivery completes, vld pulses, and the LFSR state is consumed.
  - A requester still high after its own delivery ranks lowest in the next arbitration.
- Lock-up guard: the LFSR state must never be 0. Any attempt to load 0 is replaced with 1.
- Reset values: gnt=0, vld=0, data=0, busy=0, LFSR=1, pointer=N_REQ-1, state IDLE, counter=0.
- Reset asserted mid-operation aborts immediately to these values. No vld is produced.

## Timing
- req first seen high in IDLE at cycle 0.
- gnt is high from cycle 1 through cycle STEPS+1.
- SHIFT occupies cycles 1..STEPS.
- vld and new data are at cycle STEPS+1.
- Back-to-back deliveries occur every STEPS+1 cycles. There is no IDLE bubble when requests are pending.
- Simultaneous req in IDLE: exactly one gnt bit, chosen by round robin.

## Configuration
- NOISE_ARB_SEED_LOAD_EN defined:
  - seed_we and seed ports exist.
  - seed_we in IDLE loads the LFSR with seed, or with 1 if seed is 0, on that edge. That edge's arbitration still proceeds.
  - seed_we outside IDLE is ignored.
- NOISE_ARB_SEED_LOAD_EN undefined:
  - The seed ports are absent.
  - The LFSR starts from 1 after reset and is never reloaded.

## Structure
- Package noise_pkg holds:
  - the default polynomial constant NOISE_POLY_8 = 9'h11D;
  - the state enum (IDLE, SHIFT, DELIVER);
  - the step-counter width constant (8 bits).
- Sub-module noise_lfsr_core:
  - parameters W and POLY;
  - ports clk, nCR, en, ld, ld_val, state;
  - performs the step and zero-guard.
- The arbiter and FSM stay in noise_arbiter.

## Test plan
- Reset, req=4'b0001, STEPS=8 -> gnt=0001 at cycles 1..9; vld at cycle 9 with data=0x83 (LFSR path 01→8E→47→AD→D8→6C→36→1B→83).
- req=4'b1111 held continuously -> gnt order 0,1,2,3,0; one vld every 9 cycles; busy never drops.
- req0 pulsed for 1 cycle only -> full 8-cycle SHIFT still runs; vld at cycle 9; then IDLE with gnt=0.
- nCR asserted at cycle 4 of SHIFT -> all outputs 0 immediately; no vld; next delivery after reset again yields 0x83.
- With NOISE_ARB_SEED_LOAD_EN: seed_we with seed=0x00 in IDLE, then req1 with STEPS=1 -> data=0x8E. Seed 0x00 is guarded to 0x01.
- req1 and req3 rise together after a grant to requester 2 -> req3 granted first, then req1.
